// File: rtl/demux_1x4_tdm.sv
// demux_1x4_tdm
// Receive end of the lane-select TDM path. Samples arriving on a single
// framed stream are collected slot by slot and published together as one
// registered parallel word once a full frame has arrived.
//
// State table:
//   HUNT    | no frame in progress; waiting for a valid sof
//   COLLECT | frame in progress; slot holds the next slot index (1..LANES-1)
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   din       - W-bit slot sample
//   in_valid  - qualifies din/sof; nothing advances while low
//   sof       - start of frame, marks din as slot 0
//   q         - parallel frame, lane k at q[k*W +: W]
//   out_valid - one-cycle pulse when q first shows a new frame
//   frame_err - one-cycle pulse on an early sof (truncated frame)
//   slot      - next slot index expected (monitor)
module demux_1x4_tdm #(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             din,
  input  logic                     in_valid,
  input  logic                     sof,
  output logic [LANES*W-1:0]       q,
  output logic                     out_valid,
  output logic                     frame_err,
  output logic [$clog2(LANES)-1:0] slot
);

  localparam int SW = $clog2(LANES);
  localparam logic [SW-1:0] LAST = SW'(LANES - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t state, state_n;
  logic [SW-1:0] slot_n;
  logic          wr_en;
  logic [SW-1:0] wr_idx;
  logic          commit;
  logic          err;

  // The last lane is never stored: at commit it is taken straight from din.
  logic [(LANES-1)*W-1:0] shadow;

  always_comb begin
    state_n = state;
    slot_n  = slot;
    wr_en   = 1'b0;
    wr_idx  = slot;
    commit  = 1'b0;
    err     = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (sof) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            slot_n  = SW'(1);
            state_n = COLLECT;
          end
        end
        COLLECT: begin
          if (sof) begin
            // Early sof: drop the partial frame, restart on this sample.
            err    = 1'b1;
            wr_en  = 1'b1;
            wr_idx = '0;
            slot_n = SW'(1);
          end else if (slot == LAST) begin
            commit  = 1'b1;
            slot_n  = '0;
            state_n = HUNT;
          end else begin
            wr_en  = 1'b1;
            wr_idx = slot;
            slot_n = slot + SW'(1);
          end
        end
        default: begin
          state_n = HUNT;
          slot_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      slot  <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < LANES - 1; k++) begin
        if (wr_idx == SW'(k)) shadow[k*W +: W] <= din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= commit;
      frame_err <= err;
      if (commit) q <= {din, shadow};
    end
  end

endmodule

// File: tb/tb_demux_1x4_tdm.sv
// Bench for demux_1x4_tdm: directed frames followed by random traffic, each
// cycle compared against a frame-list reference model.
module tb_demux_1x4_tdm;

  localparam int LANES = 4;
  localparam int W     = 8;
  localparam int SW    = $clog2(LANES);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [W-1:0]         din;
  logic                 in_valid;
  logic                 sof;
  logic [LANES*W-1:0]   q;
  logic                 out_valid;
  logic                 frame_err;
  logic [SW-1:0]        slot;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: samples of the frame in progress (empty = no frame).
  logic [W-1:0]       frame[$];
  logic [LANES*W-1:0] m_q;
  logic               m_ov;
  logic               m_err;
  logic               m_ov_seen;
  logic               m_err_seen;

  demux_1x4_tdm #(.LANES(LANES), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .in_valid (in_valid),
    .sof      (sof),
    .q        (q),
    .out_valid(out_valid),
    .frame_err(frame_err),
    .slot     (slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    m_q   = '0;
    m_ov  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
    m_ov  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (s) begin
        if (frame.size() != 0) m_err = 1'b1;
        frame.delete();
        frame.push_back(d);
      end else if (frame.size() != 0) begin
        frame.push_back(d);
        if (frame.size() == LANES) begin
          m_q = '0;
          for (int k = 0; k < LANES; k++) m_q[k*W +: W] = frame[k];
          m_ov = 1'b1;
          frame.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    chk("q", q, m_q);
    chk("out_valid", out_valid, m_ov);
    chk("frame_err", frame_err, m_err);
    chk("slot", slot, frame.size());
    if (out_valid) m_ov_seen = 1'b1;
    if (frame_err) m_err_seen = 1'b1;
  endtask

  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    sof      = s;
    din      = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    check_all();
  endtask

  task automatic send_frame(input logic [LANES*W-1:0] f);
    for (int k = 0; k < LANES; k++) step(1'b1, k == 0, f[k*W +: W]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    sof      = 1'b0;
    din      = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Basic frame.
    send_frame(32'h44332211);
    chk("basic_q", q, 32'h44332211);
    idle(1);

    // Stall mid-frame: slot holds at 2.
    step(1, 1, 8'h11);
    step(1, 0, 8'h22);
    idle(3);
    chk("stall_slot", slot, 2);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    chk("stall_ov", out_valid, 1);
    idle(1);

    // Samples without sof are discarded without error.
    m_err_seen = 1'b0;
    step(1, 0, 8'hAA);
    step(1, 0, 8'hBB);
    send_frame(32'h04030201);
    chk("discard_q", q, 32'h04030201);
    chk("discard_no_err", m_err_seen, 0);

    // Early sof truncates the frame.
    step(1, 1, 8'h10);
    step(1, 0, 8'h20);
    step(1, 1, 8'h55);
    chk("early_err", frame_err, 1);
    chk("early_q_hold", q, 32'h04030201);
    step(1, 0, 8'h66);
    step(1, 0, 8'h77);
    step(1, 0, 8'h88);
    chk("early_q", q, 32'h88776655);

    // Back-to-back frames.
    send_frame(32'h04030201);
    chk("b2b_q0", q, 32'h04030201);
    send_frame(32'h08070605);
    chk("b2b_q1", q, 32'h08070605);

    // Async reset mid-frame.
    send_frame(32'hDEADBEEF);
    step(1, 1, 8'h11);
    step(1, 0, 8'h22);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    chk("rst_discard_q", q, 0);
    send_frame(32'hCAFEF00D);
    chk("rst_after_q", q, 32'hCAFEF00D);

    // Random traffic.
    m_ov_seen  = 1'b0;
    m_err_seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0, W'($urandom));
    end
    chk("rand_saw_commit", m_ov_seen, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_1x4_tdm.md
Name: demux_1x4_tdm

Overview:
- Time-division demultiplexer: the receive end of the 4:1 lane-select path.
- Takes one W-bit sample per valid cycle from a single TDM stream framed by a start-of-frame marker.
- Routes slot k to output lane k.
- Publishes all LANES lanes together as one registered parallel word with a one-cycle valid pulse once a complete frame has arrived.

Parameters:
- LANES, 4, number of TDM slots/output lanes per frame; must be >= 2.
- W, 8, bits per slot sample.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  slot sample on the TDM stream.
- in_valid  input  1  din/sof qualify this cycle; when low, nothing advances.
- sof  input  1  start of frame; marks the din of this cycle as slot 0. Ignored when in_valid is low.
- q  output  LANES*W  parallel frame; lane k occupies q[k*W +: W].
- out_valid  output  1  one-cycle pulse, high in the cycle q first shows a new frame.
- frame_err  output  1  one-cycle pulse on an early sof (a frame was truncated).
- slot  output  $clog2(LANES)  index of the next slot expected (debug/monitor).

Behaviour:
- Reset (async assert, applied immediately):
  - q=0, out_valid=0, frame_err=0, slot=0.
  - Internal shadow lanes=0, state=HUNT.
  - Release is sampled synchronously on the next clk edge.
- State HUNT (no frame in progress):
  - in_valid & sof: shadow[0]<=din, slot<=1, go to COLLECT.
  - in_valid & !sof: sample discarded, no error, stay in HUNT.
  - !in_valid: hold.
- State COLLECT (frame in progress; slot = next slot index, 1..LANES-1):
  - !in_valid: hold all state; stalls of any length are allowed mid-frame.
  - in_valid & !sof & slot<LANES-1: shadow[slot]<=din, slot<=slot+1.
  - in_valid & !sof & slot==LANES-1 (commit): q<=shadow with slot LANES-1 taken directly from din; out_valid<=1; slot<=0; go to HUNT.
  - in_valid & sof (early sof, any slot in 1..LANES-1): frame_err<=1 for one cycle; the partial frame is discarded and q is unchanged. The new sample starts a new frame: shadow[0]<=din, slot<=1, stay in COLLECT.
- Latency: the last slot is accepted at edge N; q and out_valid are valid right after edge N, registered with no combinational path from din.
- Back-to-back frames: a sof in the cycle directly after a commit is accepted as slot 0 of the next frame, so full throughput is one frame per LANES valid cycles.
- Output holding:
  - q changes only on commit; it holds its value otherwise, including through errors and stalls.
  - out_valid and frame_err are cleared the cycle after they assert.
  - out_valid and frame_err are never high in the same cycle.
- Shadow lanes not rewritten in a frame cannot reach q, because a commit requires all slots 0..LANES-1 to have been written after sof.
- Reset mid-frame: the partial frame is lost, q returns to 0, and state returns to HUNT.
- Widths: slot wraps only through the explicit commit/sof paths and never counts past LANES-1. No arithmetic is performed on din.

Test Plan:
- Reset, then sof+din=0x11 followed by din 0x22, 0x33, 0x44 on consecutive valid cycles -> one edge after 0x44: q=0x44332211, out_valid high for exactly 1 cycle, slot=0.
- Same frame with in_valid low for 3 cycles between 0x22 and 0x33 -> identical q=0x44332211, a single out_valid pulse; slot holds at 2 during the stall.
- Valid din 0xAA, 0xBB without sof, then a normal frame 0x01..0x04 -> 0xAA and 0xBB discarded, q=0x04030201, frame_err never asserted.
- sof 0x10, din 0x20, then sof 0x55, din 0x66, 0x77, 0x88 -> frame_err pulses once on the second sof; q unchanged until commit, then q=0x88776655.
- Two back-to-back frames (0x01..0x04, then sof 0x05..0x08 immediately after) -> two out_valid pulses 4 cycles apart; q=0x04030201, then q=0x08070605.
- Assert rst asynchronously after slot 2 of a frame (q previously 0xDEADBEEF) -> q=0 and out_valid=0 immediately; the remaining slots without sof are discarded; the next full frame commits normally.
